// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the main-memory port arbiter.
//   arbState_e : arbiter sequencing states (IDLE, ACCESS, DONE)
//   owner_e    : which cache owns the current transaction (OWN_I / OWN_D)
//   BLOCK_OFFSET_BITS / WORD_OFFSET_BITS : low address bits cleared on
//     128-bit block reads and 32-bit word writes respectively
//   alignAddr  : address alignment helper used when a request is granted
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arbState_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_OFFSET_BITS  = 2;

  localparam logic [31:0] BLOCK_MASK = ~((32'd1 << BLOCK_OFFSET_BITS) - 32'd1);
  localparam logic [31:0] WORD_MASK  = ~((32'd1 << WORD_OFFSET_BITS) - 32'd1);

  // Writes are word-aligned, block reads are block-aligned.
  function automatic logic [31:0] alignAddr(input logic [31:0] addr,
                                            input logic        isWrite);
    alignAddr = isWrite ? (addr & WORD_MASK) : (addr & BLOCK_MASK);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two cache request ports and the RAM port of the arbiter.
//   I-cache : ireq_i, iaddr_i                      (block reads only)
//   D-cache : ireq_d, iwe_d, iaddr_d, iwdata_d     (block read or word write)
//   RAM     : oram_addr, oram_wdata, oram_re, oram_we, iram_rdata
//   Status  : odone_i, odone_d, ordata, obusy
// Modports:
//   master : the arbiter side (drives the RAM strobes and done pulses)
//   slave  : the environment side (caches and RAM model)
//
// Handshake: a requester raises its req together with stable addr/we/wdata
// and holds all of them unchanged until the cycle in which its done pulse is
// high; that one-cycle done pulse is the acknowledge and ordata is valid while
// it is high. In the following cycle the requester either drops req or keeps
// it high, in which case the arbiter treats it as a brand-new transaction.
// The RAM samples oram_addr/oram_wdata only while oram_re or oram_we is high
// and must present iram_rdata in the last cycle of a read strobe.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

  logic         ireq_i;
  logic [31:0]  iaddr_i;
  logic         ireq_d;
  logic         iwe_d;
  logic [31:0]  iaddr_d;
  logic [31:0]  iwdata_d;
  logic [127:0] iram_rdata;
  logic [31:0]  oram_addr;
  logic [31:0]  oram_wdata;
  logic         oram_re;
  logic         oram_we;
  logic         odone_i;
  logic         odone_d;
  logic [127:0] ordata;
  logic         obusy;

  modport master (
    input  ireq_i, iaddr_i, ireq_d, iwe_d, iaddr_d, iwdata_d, iram_rdata,
    output oram_addr, oram_wdata, oram_re, oram_we,
    output odone_i, odone_d, ordata, obusy
  );

  modport slave (
    output ireq_i, iaddr_i, ireq_d, iwe_d, iaddr_d, iwdata_d, iram_rdata,
    input  oram_addr, oram_wdata, oram_re, oram_we,
    input  odone_i, odone_d, ordata, obusy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single main-memory port between the I-cache refill path and the
// D-cache. One transaction at a time; on a simultaneous request the cache that
// was not served last wins. The RAM strobe is held for LATENCY cycles, read
// data is captured in the last strobe cycle and returned with a one-cycle
// done pulse to the owning cache.
//
// Parameters:
//   LATENCY  : RAM access time in cycles, legal range 1..15
// Ports:
//   clk      : clock, all state on the rising edge
//   rst      : asynchronous, active-high reset
//   bus      : request / RAM / status bundle (mem_port_arbiter_if.master)
//   dbgState : current sequencing state, for observation only
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus,
  output arbState_e           dbgState
);

  arbState_e    state;
  logic [3:0]   cnt;
  owner_e       ownerLast;
  owner_e       ownerLat;
  logic         weLat;

  logic [31:0]  ramAddr;
  logic [31:0]  ramWdata;
  logic         ramRe;
  logic         ramWe;
  logic         doneI;
  logic         doneD;
  logic [127:0] rdataReg;
  logic         busy;

  // Grant selection, evaluated only while IDLE.
  logic         anyReq;
  owner_e       pick;
  logic         pickWe;
  logic [31:0]  pickAddr;

  assign anyReq = bus.ireq_i | bus.ireq_d;

  always_comb begin
    pick     = OWN_I;
    pickWe   = 1'b0;
    pickAddr = bus.iaddr_i;
    // Two-way round robin: on a tie the cache not served last wins.
    if (bus.ireq_i && bus.ireq_d) begin
      pick = (ownerLast == OWN_I) ? OWN_D : OWN_I;
    end else if (bus.ireq_d) begin
      pick = OWN_D;
    end
    if (pick == OWN_D) begin
      pickWe   = bus.iwe_d;
      pickAddr = bus.iaddr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ownerLast <= OWN_I;
      ownerLat  <= OWN_I;
      weLat     <= 1'b0;
      ramAddr   <= 32'd0;
      ramWdata  <= 32'd0;
      ramRe     <= 1'b0;
      ramWe     <= 1'b0;
      doneI     <= 1'b0;
      doneD     <= 1'b0;
      rdataReg  <= 128'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            ownerLat <= pick;
            weLat    <= pickWe;
            // Strobes and address are registered here so they are valid
            // from the very first ACCESS cycle.
            ramAddr  <= alignAddr(pickAddr, pickWe);
            if (pick == OWN_D) begin
              ramWdata <= bus.iwdata_d;
            end
            ramRe    <= ~pickWe;
            ramWe    <= pickWe;
            cnt      <= 4'(LATENCY - 1);
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end

        ACCESS: begin
          if (cnt == 4'd0) begin
            // Last strobe cycle: RAM data is valid now. Writes keep the
            // previous read data on ordata.
            if (!weLat) begin
              rdataReg <= bus.iram_rdata;
            end
            ownerLast <= ownerLat;
            ramRe     <= 1'b0;
            ramWe     <= 1'b0;
            doneI     <= (ownerLat == OWN_I);
            doneD     <= (ownerLat == OWN_D);
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          // Requests seen here wait for the next IDLE cycle.
          doneI <= 1'b0;
          doneD <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.oram_addr  = ramAddr;
  assign bus.oram_wdata = ramWdata;
  assign bus.oram_re    = ramRe;
  assign bus.oram_we    = ramWe;
  assign bus.odone_i    = doneI;
  assign bus.odone_d    = doneD;
  assign bus.ordata     = rdataReg;
  assign bus.obusy      = busy;
  assign dbgState       = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Randomized bench for mem_port_arbiter. A transaction-level reference model
// predicts, from the grant cycle alone, when strobes, done pulses and read
// data must appear. A second instance with LATENCY=1 is exercised with a held
// I-cache request.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT  = 4;
  localparam int NCYC = 2500;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rst1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter_if bus1();
  arbState_e dbgState;
  arbState_e dbgState1;

  mem_port_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbgState(dbgState)
  );

  mem_port_arbiter #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .dbgState(dbgState1)
  );

  // ---------------- scoreboard ----------------
  int errCnt = 0;
  int chkCnt = 0;
  logic [0:0] exp_q[$];     // expected done-owner order of the first four
  logic [0:0] doneOrder[$]; // observed done-owner order
  bit lat1Done = 1'b0;

  task automatic checkVal(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  bit iActive, dActive;

  task automatic newI();
    bus.ireq_i  = 1'b1;
    bus.iaddr_i = $urandom();
    iActive     = 1'b1;
  endtask

  task automatic dropI();
    bus.ireq_i = 1'b0;
    iActive    = 1'b0;
  endtask

  task automatic newD();
    bus.ireq_d    = 1'b1;
    bus.iwe_d     = 1'($urandom_range(1, 0));
    bus.iaddr_d   = $urandom();
    bus.iwdata_d  = $urandom();
    dActive       = 1'b1;
  endtask

  task automatic dropD();
    bus.ireq_d = 1'b0;
    dActive    = 1'b0;
  endtask

  // ---------------- reference model state ----------------
  bit           txValid;
  int           gEdge;
  owner_e       tOwn;
  bit           tWe;
  logic [31:0]  tAddr;
  logic [31:0]  tWdata;
  logic [127:0] tRdata;
  owner_e       lastOwn;
  logic [127:0] expOrdata;
  int           nTx;
  int           obsDones, expDones;

  // ---------------- main LATENCY=4 sequence ----------------
  initial begin
    bit rstNow;
    int off;
    int rstHold;
    int shots;
    int nextShot;
    bit expRe, expWe, expDi, expDd, expBusy;
    arbState_e expState;

    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};  // D, I, D, I
    rst = 1'b1;
    bus.ireq_i = 1'b0; bus.iaddr_i = 32'd0;
    bus.ireq_d = 1'b0; bus.iwe_d = 1'b0; bus.iaddr_d = 32'd0;
    bus.iwdata_d = 32'd0; bus.iram_rdata = 128'd0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rstState", 128'(dbgState), 128'(IDLE));
    checkVal("rstRe", 128'(bus.oram_re), 128'd0);
    checkVal("rstWe", 128'(bus.oram_we), 128'd0);
    checkVal("rstAddr", 128'(bus.oram_addr), 128'd0);
    checkVal("rstWdata", 128'(bus.oram_wdata), 128'd0);
    checkVal("rstDoneI", 128'(bus.odone_i), 128'd0);
    checkVal("rstDoneD", 128'(bus.odone_d), 128'd0);
    checkVal("rstOrdata", bus.ordata, 128'd0);
    checkVal("rstBusy", 128'(bus.obusy), 128'd0);

    // First requests arrive together: I read and D write.
    rst = 1'b0;
    bus.ireq_i = 1'b1; bus.iaddr_i = 32'h0000_1234;
    bus.ireq_d = 1'b1; bus.iwe_d = 1'b1; bus.iaddr_d = 32'h0000_0106;
    bus.iwdata_d = 32'hDEAD_BEEF;
    iActive = 1'b1; dActive = 1'b1;
    txValid = 1'b0; gEdge = 0; lastOwn = OWN_I; expOrdata = 128'd0;
    nTx = 0; obsDones = 0; expDones = 0;
    tOwn = OWN_I; tWe = 1'b0; tAddr = 32'd0; tWdata = 32'd0; tRdata = 128'd0;
    rstHold = 0; shots = 3; nextShot = 300;

    for (int e = 0; e < NCYC; e++) begin
      @(posedge clk);
      #1;
      rstNow = rst;

      // Grant: the port is free LAT+2 edges after the previous grant.
      if (!rstNow && (!txValid || e >= gEdge + LAT + 2) &&
          (bus.ireq_i || bus.ireq_d)) begin
        if (bus.ireq_i && bus.ireq_d)
          tOwn = (lastOwn == OWN_I) ? OWN_D : OWN_I;
        else
          tOwn = bus.ireq_d ? OWN_D : OWN_I;
        tWe    = (tOwn == OWN_D) && bus.iwe_d;
        tAddr  = (tOwn == OWN_D) ? bus.iaddr_d : bus.iaddr_i;
        tWdata = bus.iwdata_d;
        nTx++;
        tRdata = (nTx == 2) ? {16{8'hA5}} : rand128();
        txValid = 1'b1;
        gEdge   = e;
      end

      off = txValid ? (e - gEdge) : 1000;
      expRe = 0; expWe = 0; expDi = 0; expDd = 0; expBusy = 0;
      expState = IDLE;
      if (off < LAT) begin
        expRe = !tWe; expWe = tWe; expBusy = 1; expState = ACCESS;
        checkVal("addr", 128'(bus.oram_addr),
                 128'(tWe ? (tAddr & 32'hFFFF_FFFC) : (tAddr & 32'hFFFF_FFF0)));
        if (tWe) checkVal("wdata", 128'(bus.oram_wdata), 128'(tWdata));
      end else if (off == LAT) begin
        lastOwn = tOwn;
        expDi = (tOwn == OWN_I); expDd = (tOwn == OWN_D);
        expBusy = 1; expState = DONE;
        if (!tWe) expOrdata = tRdata;
      end
      checkVal("re", 128'(bus.oram_re), 128'(expRe));
      checkVal("we", 128'(bus.oram_we), 128'(expWe));
      checkVal("doneI", 128'(bus.odone_i), 128'(expDi));
      checkVal("doneD", 128'(bus.odone_d), 128'(expDd));
      checkVal("busy", 128'(bus.obusy), 128'(expBusy));
      checkVal("state", 128'(dbgState), 128'(expState));
      checkVal("ordata", bus.ordata, expOrdata);

      if (bus.odone_i || bus.odone_d) begin
        obsDones++;
        if (doneOrder.size() < 4) doneOrder.push_back(bus.odone_d);
      end
      if (expDi || expDd) expDones++;

      // Reset injection in the second ACCESS cycle, and its release.
      if (rst) begin
        rstHold--;
        if (rstHold == 0) rst = 1'b0;
      end else if (shots > 0 && off == 1 && e > nextShot) begin
        rst = 1'b1;
        #1;
        checkVal("midRstRe", 128'(bus.oram_re), 128'd0);
        checkVal("midRstWe", 128'(bus.oram_we), 128'd0);
        checkVal("midRstBusy", 128'(bus.obusy), 128'd0);
        checkVal("midRstOrdata", bus.ordata, 128'd0);
        txValid = 1'b0; expOrdata = 128'd0; lastOwn = OWN_I;
        rstHold = 2; shots--; nextShot = e + 600;
      end

      // RAM model: valid data only in the last read strobe cycle.
      off = txValid ? (e - gEdge) : 1000;
      if (off == LAT - 1 && !tWe) bus.iram_rdata = tRdata;
      else bus.iram_rdata = rand128();

      // Requesters: free in the IDLE cycle following their done pulse.
      if (off == LAT + 1) begin
        if (tOwn == OWN_I) begin
          if (nTx > 3) begin
            if ($urandom_range(1, 0) == 1) newI(); else dropI();
          end
        end else begin
          if (nTx > 3) begin
            if ($urandom_range(1, 0) == 1) newD(); else dropD();
          end
        end
      end
      if (!iActive && $urandom_range(2, 0) == 0) newI();
      if (!dActive && $urandom_range(2, 0) == 0) newD();
    end

    checkVal("doneCount", 128'(obsDones), 128'(expDones));
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("grantOrder%0d", i),
               (i < doneOrder.size()) ? 128'(doneOrder[i]) : {128{1'bx}},
               128'(exp_q[i]));
    end

    for (int k = 0; k < 200 && !lat1Done; k++) @(posedge clk);
    checkVal("lat1Finished", 128'(lat1Done), 128'd1);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

  // ---------------- LATENCY=1, held I-cache request ----------------
  initial begin
    logic [127:0] lastRd;
    logic [31:0]  addr1;
    bit prevRe, prevDoneCyc;
    int prevDone;
    int nDone;

    rst1 = 1'b1;
    bus1.ireq_i = 1'b0; bus1.iaddr_i = 32'd0;
    bus1.ireq_d = 1'b0; bus1.iwe_d = 1'b0; bus1.iaddr_d = 32'd0;
    bus1.iwdata_d = 32'd0; bus1.iram_rdata = 128'd0;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0;
    addr1 = $urandom();
    bus1.ireq_i = 1'b1; bus1.iaddr_i = addr1;
    lastRd = rand128(); bus1.iram_rdata = lastRd;
    prevRe = 1'b0; prevDoneCyc = 1'b0; prevDone = -1; nDone = 0;

    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (bus1.oram_re) begin
        checkVal("lat1Single", 128'(prevRe), 128'd0);
        checkVal("lat1Addr", 128'(bus1.oram_addr), 128'(addr1 & 32'hFFFF_FFF0));
      end
      checkVal("lat1DoneD", 128'(bus1.odone_d), 128'd0);
      if (bus1.odone_i) begin
        nDone++;
        checkVal("lat1PrevRe", 128'(prevRe), 128'd1);
        checkVal("lat1Data", bus1.ordata, lastRd);
        checkVal("lat1State", 128'(dbgState1), 128'(DONE));
        if (prevDone >= 0) checkVal("lat1Gap", 128'(c - prevDone), 128'd3);
        prevDone = c;
      end
      // New address once the done cycle has passed; request stays high.
      if (prevDoneCyc) begin
        addr1 = $urandom();
        bus1.iaddr_i = addr1;
      end
      prevDoneCyc = bus1.odone_i;
      prevRe = bus1.oram_re;
      lastRd = rand128();
      bus1.iram_rdata = lastRd;
    end
    checkVal("lat1Count", 128'(nDone >= 12), 128'd1);
    lat1Done = 1'b1;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single main-memory (RAM) port shared by the instruction-cache refill path and the data cache in the memory stage. Accepts 128-bit block-read requests from the I-cache and either 128-bit block reads or 32-bit write-throughs from the D-cache. Grants one transaction at a time, round-robin on conflict. Drives the RAM strobes for a fixed access latency and returns read data with a one-cycle done pulse.

## Interface
- LATENCY, 4, RAM access time in cycles; legal range 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ireq_i  in  1  I-cache block-read request; held until done
- iaddr_i  in  32  I-cache byte address
- ireq_d  in  1  D-cache request; held until done
- iwe_d  in  1  D-cache request is a write (1) or block read (0)
- iaddr_d  in  32  D-cache byte address
- iwdata_d  in  32  D-cache write data
- iram_rdata  in  128  RAM read data, valid in last access cycle
- oram_addr  out  32  RAM address
- oram_wdata  out  32  RAM write data
- oram_re  out  1  RAM read strobe
- oram_we  out  1  RAM write strobe
- odone_i  out  1  one-cycle pulse, I-cache transaction complete
- odone_d  out  1  one-cycle pulse, D-cache transaction complete
- ordata  out  128  registered read data, valid while a done pulse is high
- obusy  out  1  transaction in progress (state != IDLE)

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if no request, stay. If exactly one requester is asserting, grant it. If both are asserting, grant the requester not granted last (owner_last). Latch owner, address, we, wdata; set the counter to LATENCY-1; go to ACCESS.
- ACCESS: oram_re = !we_lat, oram_we = we_lat, oram_wdata = wdata_lat, all from latched values.
  - oram_addr = {addr[31:4],4'b0} for reads and {addr[31:2],2'b0} for writes.
  - Counter decrements each cycle. At count 0: capture iram_rdata into ordata (reads only; writes leave ordata unchanged), update owner_last, go to DONE.
- DONE: assert odone_i or odone_d per owner for exactly this cycle, then go to IDLE. Strobes are low.
- Requester protocol:
  - Hold req, addr, we and wdata stable from assertion until the cycle its done pulse is seen.
  - Deassert req the following cycle, or keep it high to request again. A request still high in IDLE is a new transaction.
- A request dropped during ACCESS is a protocol violation. The arbiter still completes the transaction and pulses done.
- A request arriving during ACCESS or DONE waits. It is evaluated in the next IDLE cycle.
- Outputs oram_addr and oram_wdata hold their last value outside ACCESS. The RAM qualifies them by its strobes only.

## Timing
- Request sampled high at edge 0 (IDLE) → ACCESS in cycles 1..LATENCY → done pulse in cycle LATENCY+1 → IDLE in cycle LATENCY+2.
- Request-to-done latency is LATENCY+1 cycles. Back-to-back throughput is one transaction per LATENCY+2 cycles.
- Reset values (async on rst high): state IDLE, oram_re 0, oram_we 0, oram_addr 0, oram_wdata 0, odone_i 0, odone_d 0, ordata 0, obusy 0, counter 0.
- Reset value of owner_last is I-cache, so the D-cache wins the first tie.
- Reset mid-ACCESS aborts the transaction: strobes drop immediately and no done pulse is issued. Requesters must re-request after reset.
- Counter width is 4 bits. LATENCY=1 gives a single ACCESS cycle.
- A simultaneous new request and done in DONE cause no grant until IDLE. There is no zero-gap grant.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - the owner encoding (OWN_I=0, OWN_D=1);
  - the BLOCK_OFFSET_BITS=4 and WORD_OFFSET_BITS=2 constants.
- Single flat module; no sub-module is warranted. The two-way round-robin pick is one expression.

## Test plan
- I-cache read alone: ireq_i=1, iaddr_i=0x0000_1234, LATENCY=4, RAM returns 0xA5…A5.
  - Required: oram_addr=0x0000_1230, oram_re high cycles 1–4, odone_i in cycle 5, ordata=0xA5…A5, odone_d never high.
- D-cache write: ireq_d=1, iwe_d=1, iaddr_d=0x0000_0106, iwdata_d=0xDEADBEEF.
  - Required: oram_we high 4 cycles, oram_addr=0x0000_0104, oram_wdata=0xDEADBEEF, odone_d in cycle 5, ordata unchanged, oram_re never high.
- Simultaneous first requests after reset (both held high) → D-cache granted first and I-cache second. Grants alternate D, I, D, I over 4 transactions.
- I-cache request arriving mid D-cache ACCESS → held off. Granted in the IDLE cycle after odone_d; its odone_i follows LATENCY+2 cycles after odone_d.
- rst asserted in cycle 2 of ACCESS → oram_re 0 in the same cycle, no done pulse. After release, a held request completes normally with the full latency.
- LATENCY=1, repeated I-cache reads → one ACCESS cycle each, done every 3 cycles, ordata correct per transaction.
